// File: rtl/dds_voice_sched.sv
// Multi-voice DDS scheduler: one shared phase adder is time-multiplexed over
// all voices. A sample tick starts a sweep that emits one waveform sample per
// voice per cycle, in ascending voice order.
module dds_voice_sched #(
  parameter int WIDTH  = 32,
  parameter int VOICES = 4,
  localparam int VW    = $clog2(VOICES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [VW-1:0]    cfg_voice,
  input  logic [WIDTH-1:0] cfg_inc,
  input  logic [2:0]       cfg_wave,
  input  logic [6:0]       cfg_pwm,
  input  logic             cfg_gate,
  output logic             busy,
  output logic             out_valid,
  output logic [VW-1:0]    out_voice,
  output logic [WIDTH-1:0] out_sample,
  output logic             overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [VW-1:0]    idx;

  logic [WIDTH-1:0] phase [VOICES];
  logic [WIDTH-1:0] inc   [VOICES];
  logic [2:0]       wave  [VOICES];
  logic [6:0]       pwm   [VOICES];
  logic             gate  [VOICES];

  logic [WIDTH-1:0] new_phase;
  logic [WIDTH-1:0] new_sample;

  function automatic logic [WIDTH-1:0] wave_of(input logic [2:0] w,
                                               input logic [WIDTH-1:0] p,
                                               input logic [6:0] duty);
    logic [WIDTH-1:0] r;
    r = '0;
    case (w)
      3'd0: r = p;
      3'd1: r = ~p;
      3'd2: r = p[WIDTH-1] ? {~p[WIDTH-2:0], 1'b0} : {p[WIDTH-2:0], 1'b0};
      3'd3: r = p[WIDTH-1] ? '0 : '1;
      3'd4: r = (p[WIDTH-1 -: 7] < duty) ? '1 : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);

  // Shared adder and waveform shaper for the voice currently selected by idx
  always_comb begin
    new_phase  = '0;
    new_sample = '0;
    if (gate[idx]) begin
      new_phase  = phase[idx] + inc[idx];
      new_sample = wave_of(wave[idx], new_phase, pwm[idx]);
    end
  end

  // Sweep FSM, per-voice state, configuration writes and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_voice  <= '0;
      out_sample <= '0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
        wave[i]  <= '0;
        pwm[i]   <= '0;
        gate[i]  <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      if (cfg_valid && state == IDLE) begin
        inc[cfg_voice]  <= cfg_inc;
        wave[cfg_voice] <= cfg_wave;
        pwm[cfg_voice]  <= cfg_pwm;
        gate[cfg_voice] <= cfg_gate;
      end
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          phase[idx] <= new_phase;
          out_valid  <= 1'b1;
          out_voice  <= idx;
          out_sample <= new_sample;
          idx        <= idx + 1'b1;
          if (idx == VW'(VOICES - 1)) state <= IDLE;
          if (sample_tick) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_voice_sched.sv
// Directed bench for dds_voice_sched with hand-computed expected samples.
module tb_dds_voice_sched;

  localparam int WIDTH  = 32;
  localparam int VOICES = 4;
  localparam int VW     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_tick;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [VW-1:0]    cfg_voice;
  logic [WIDTH-1:0] cfg_inc;
  logic [2:0]       cfg_wave;
  logic [6:0]       cfg_pwm;
  logic             cfg_gate;
  logic             busy;
  logic             out_valid;
  logic [VW-1:0]    out_voice;
  logic [WIDTH-1:0] out_sample;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] samp [VOICES];

  dds_voice_sched #(.WIDTH(WIDTH), .VOICES(VOICES)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
    .cfg_inc(cfg_inc), .cfg_wave(cfg_wave), .cfg_pwm(cfg_pwm),
    .cfg_gate(cfg_gate), .busy(busy), .out_valid(out_valid),
    .out_voice(out_voice), .out_sample(out_sample), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Collects one sweep's samples; call right after the tick edge
  task automatic collect_sweep();
    for (int k = 0; k < VOICES; k++) begin
      @(negedge clk);
      check("sweep_valid", {31'd0, out_valid}, 32'd1);
      check("sweep_voice", {30'd0, out_voice}, k);
      samp[k] = out_sample;
    end
  endtask

  task automatic sweep();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    collect_sweep();
  endtask

  task automatic cfg_write(input int v, input logic [WIDTH-1:0] i,
                           input logic [2:0] w, input logic [6:0] d,
                           input logic g);
    int n;
    cfg_valid = 1'b1;
    cfg_voice = VW'(v);
    cfg_inc = i; cfg_wave = w; cfg_pwm = d; cfg_gate = g;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("cfg_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int nv, no;
    reset = 1'b1; sample_tick = 1'b0; cfg_valid = 1'b0;
    cfg_voice = '0; cfg_inc = '0; cfg_wave = '0; cfg_pwm = '0; cfg_gate = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_sample", out_sample, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Voice 0 saw, ungated voices silent
    cfg_write(0, 32'd33333333, 3'd0, 7'd0, 1'b1);
    sweep();
    check("v0_s1", samp[0], 32'd33333333);
    check("v1_off", samp[1], 32'd0);
    check("v2_off", samp[2], 32'd0);
    check("v3_off", samp[3], 32'd0);
    sweep();
    check("v0_s2", samp[0], 32'd66666666);

    // Voice 1 half-scale increment wraps around
    cfg_write(1, 32'h8000_0000, 3'd0, 7'd0, 1'b1);
    sweep(); check("v1_s1", samp[1], 32'h8000_0000);
    sweep(); check("v1_s2", samp[1], 32'h0000_0000);
    sweep(); check("v1_s3", samp[1], 32'h8000_0000);

    // Voice 2 pwm threshold edges, then triangle fold
    cfg_write(2, 32'h3FFF_FFFF, 3'd4, 7'd32, 1'b1);
    sweep(); check("pwm_below", samp[2], 32'hFFFF_FFFF);
    cfg_write(2, 32'h0000_0001, 3'd4, 7'd32, 1'b1);
    sweep(); check("pwm_at", samp[2], 32'h0000_0000);
    cfg_write(2, 32'h8000_0000, 3'd2, 7'd32, 1'b1);
    sweep(); check("tria", samp[2], 32'h7FFF_FFFE);
    cfg_write(3, 32'h0000_0000, 3'd5, 7'd0, 1'b1);
    sweep(); check("silent", samp[3], 32'd0);

    // Back-to-back tick: one sweep plus one overrun pulse
    sample_tick = 1'b1;
    @(negedge clk);
    nv = 0; no = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      if (out_valid) nv++;
      if (overrun) no++;
    end
    check("b2b_valid_cnt", nv, VOICES);
    check("b2b_overrun_cnt", no, 1);

    // Tick on the final sweep edge is ignored and flagged
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("last_overrun", {31'd0, overrun}, 32'd1);
    check("last_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("last_no_restart", {31'd0, busy}, 32'd0);
    check("last_no_valid", {31'd0, out_valid}, 32'd0);
    check("overrun_pulse", {31'd0, overrun}, 32'd0);

    // Reset mid-sweep
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sample_tick = 1'b1;
    cfg_valid = 1'b1; cfg_voice = 2'd0; cfg_inc = 32'd7; cfg_gate = 1'b1;
    @(negedge clk);
    reset = 1'b0; sample_tick = 1'b0; cfg_valid = 1'b0;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rstmid_idle", {31'd0, busy}, 32'd0);
    sweep();
    check("rstmid_v0", samp[0], 32'd0);
    check("rstmid_v1", samp[1], 32'd0);
    cfg_write(0, 32'd33333333, 3'd0, 7'd0, 1'b1);
    sweep();
    check("fresh_v0", samp[0], 32'd33333333);

    // cfg held through a sweep lands on the first IDLE edge with a tick
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    cfg_valid = 1'b1; cfg_voice = 2'd0; cfg_inc = 32'd5;
    cfg_wave = 3'd0; cfg_pwm = 7'd0; cfg_gate = 1'b1;
    check("hold_not_ready", {31'd0, cfg_ready}, 32'd0);
    collect_sweep();
    check("hold_old_inc", samp[0], 32'd66666666);
    check("hold_ready", {31'd0, cfg_ready}, 32'd1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    cfg_valid = 1'b0;
    collect_sweep();
    check("hold_new_inc", samp[0], 32'd66666671);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
